// File: rtl/tm_clause_eval.sv
// ---------------------------------------------------------------------------
// tm_clause_eval
//   Sequential clause-evaluation engine for the Iris Tsetlin-machine
//   classifier. Holds one include mask per clause, latches a booleanized
//   sample and evaluates one clause per cycle. The resulting 2-bit
//   positive/negative clause vectors per class go to the sum-and-threshold
//   voter.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cfg_we          include-mask write strobe (accepted in IDLE only)
//   cfg_addr        clause index 0..NC-1 (out-of-range writes are dropped)
//   cfg_data        include mask, bit k -> x[k], bit N_FEAT+k -> ~x[k]
//   cfg_ready       high while a config write can be accepted
//   in_valid/ready  sample handshake; x is the booleanized sample
//   out_valid/ready clause-vector handshake
//   pos/neg_clause_1..3  clause outputs, bit j = clause j of that group
//
// Clause index mapping: idx = class*4 + pol*2 + j (pol 0 = pos, 1 = neg).
// Timing: sample accepted at edge T, clauses 0..NC-1 are registered at edges
// T+1..T+NC, DONE is entered at edge T+NC and out_valid is therefore seen
// high by the downstream at edge T+NC+1.
// ---------------------------------------------------------------------------
module tm_clause_eval #(
  parameter int N_FEAT   = 16,
  parameter int N_CLAUSE = 2,
  parameter int N_CLASS  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [2*N_FEAT-1:0] cfg_data,
  output logic                cfg_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_FEAT-1:0]   x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          pos_clause_1,
  output logic [1:0]          neg_clause_1,
  output logic [1:0]          pos_clause_2,
  output logic [1:0]          neg_clause_2,
  output logic [1:0]          pos_clause_3,
  output logic [1:0]          neg_clause_3
);

  localparam int unsigned NC = N_CLASS * 2 * N_CLAUSE;
  localparam int unsigned NL = 2 * N_FEAT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [NL-1:0]     mask [NC];
  logic [N_FEAT-1:0] sample;
  logic [3:0]        cnt;
  logic [NC-1:0]     clause;

  logic [NL-1:0]     lits;
  logic [NL-1:0]     cur_mask;
  logic              cur_fire;
  logic              accept;
  logic              cfg_wr;
  logic              last;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  always_comb begin
    accept    = (state == S_IDLE) && in_valid;
    cfg_wr    = (state == S_IDLE) && cfg_we && (cfg_addr < 4'(NC));
    last      = (cnt == 4'(NC - 1));
    in_ready  = (state == S_IDLE);
    cfg_ready = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Clause evaluation: literal vector is {~x, x}; a clause fires when every
  // included literal is 1. An empty mask never fires (inference convention).
  // -------------------------------------------------------------------------
  always_comb begin
    lits     = {~sample, sample};
    cur_mask = mask[cnt];
    cur_fire = (|cur_mask) && ((lits & cur_mask) == cur_mask);
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_EVAL;
      S_EVAL: if (last) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Mask store. A write coinciding with sample acceptance lands at the same
  // edge the sample is latched, so the evaluation that follows sees it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NC; i++) mask[i] <= '0;
    end else if (cfg_wr) begin
      mask[cfg_addr] <= cfg_data;
    end
  end

  // -------------------------------------------------------------------------
  // Sample register, clause counter and clause-output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
      cnt    <= '0;
      clause <= '0;
    end else begin
      if (accept) begin
        sample <= x;
        cnt    <= '0;
        clause <= '0;
      end else if (state == S_EVAL) begin
        clause[cnt] <= cur_fire;
        cnt         <= last ? '0 : cnt + 4'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping: class c, polarity p occupies clause[c*4+p*2 +: 2]
  // -------------------------------------------------------------------------
  always_comb begin
    pos_clause_1 = clause[1:0];
    neg_clause_1 = clause[3:2];
    pos_clause_2 = clause[5:4];
    neg_clause_2 = clause[7:6];
    pos_clause_3 = clause[9:8];
    neg_clause_3 = clause[11:10];
  end

endmodule

// File: tb/tb_tm_clause_eval.sv
// ---------------------------------------------------------------------------
// tb_tm_clause_eval
//   Directed self-checking bench for tm_clause_eval. Inputs are driven and
//   outputs sampled on the falling clock edge. vec packs the six clause
//   vectors so that vec[i] is clause index i.
// ---------------------------------------------------------------------------
module tb_tm_clause_eval;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_ready;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  pos_clause_1, neg_clause_1;
  logic [1:0]  pos_clause_2, neg_clause_2;
  logic [1:0]  pos_clause_3, neg_clause_3;
  logic [11:0] vec;

  int unsigned n_pass;
  int unsigned n_total;

  tm_clause_eval #(.N_FEAT(16), .N_CLAUSE(2), .N_CLASS(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x            (x),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pos_clause_1 (pos_clause_1),
    .neg_clause_1 (neg_clause_1),
    .pos_clause_2 (pos_clause_2),
    .neg_clause_2 (neg_clause_2),
    .pos_clause_3 (pos_clause_3),
    .neg_clause_3 (neg_clause_3)
  );

  assign vec = {neg_clause_3, pos_clause_3, neg_clause_2,
                pos_clause_2, neg_clause_1, pos_clause_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write_cfg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Present a sample (optionally with a same-cycle config write) and return
  // on the falling edge right after the accepting rising edge. x is then
  // scrambled to show the latched copy is what gets evaluated.
  task automatic launch(input logic [15:0] xv, input logic we,
                        input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    x = xv; in_valid = 1'b1;
    cfg_we = we; cfg_addr = a; cfg_data = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; x = ~xv;
  endtask

  // Called 'skip' falling edges after launch returned. out_valid must still
  // be low after edge T+11 and high after edge T+12 (seen at edge T+13).
  task automatic wait_result(input string tag, input int unsigned skip);
    repeat (11 - skip) @(negedge clk);
    check({tag, "_lat_lo"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_lat_hi"}, 32'(out_valid), 32'd1);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; x = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_vec",       32'(vec),       32'd0);

    // All masks empty -> nothing fires even for all-ones sample
    launch(16'hFFFF, 1'b0, 4'd0, 32'd0);
    wait_result("empty", 0);
    check("empty_vec", 32'(vec), 32'd0);
    release_out("empty");

    // Single includes: clause0 = x[0], clause5 = ~x[1]; addr 12 is dropped
    write_cfg(4'd0, 32'h0000_0001);
    write_cfg(4'd5, 32'h0002_0000);
    write_cfg(4'd12, 32'hFFFF_FFFF);
    launch(16'h0001, 1'b0, 4'd0, 32'd0);
    wait_result("single1", 0);
    check("single1_vec",  32'(vec),          32'h021);
    check("single1_pos1", 32'(pos_clause_1), 32'd1);
    check("single1_pos2", 32'(pos_clause_2), 32'd2);
    release_out("single1");
    launch(16'h0003, 1'b0, 4'd0, 32'd0);
    wait_result("single3", 0);
    check("single3_vec", 32'(vec), 32'h001);
    release_out("single3");

    // Contradictory clause10 = x[3] & ~x[3]
    write_cfg(4'd10, 32'h0008_0008);
    launch(16'h0008, 1'b0, 4'd0, 32'd0);
    wait_result("contra8", 0);
    check("contra8_vec", 32'(vec), 32'h020);
    release_out("contra8");
    launch(16'h0000, 1'b0, 4'd0, 32'd0);
    wait_result("contra0", 0);
    check("contra0_vec", 32'(vec), 32'h020);
    release_out("contra0");

    // Backpressure: hold 20 cycles with a competing sample offered
    launch(16'h0001, 1'b0, 4'd0, 32'd0);
    wait_result("bp", 0);
    in_valid = 1'b1; x = 16'h0003;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {19'd0, out_valid, in_ready, vec}, {19'd0, 1'b1, 1'b0, 12'h021});
    end
    in_valid = 1'b0;
    release_out("bp");
    repeat (2) @(negedge clk);
    check("bp_no_accept", 32'(out_valid), 32'd0);

    // Config write during EVAL (clause11 = x[0]) must be ignored
    launch(16'h0001, 1'b0, 4'd0, 32'd0);
    check("gate_cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_we = 1'b1; cfg_addr = 4'd11; cfg_data = 32'h0000_0001;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_result("gate", 1);
    check("gate_vec", 32'(vec), 32'h021);
    release_out("gate");

    // Same-cycle write + accept uses the new clause11 mask
    launch(16'h0001, 1'b1, 4'd11, 32'h0000_0001);
    wait_result("simul", 0);
    check("simul_vec", 32'(vec), 32'h821);
    release_out("simul");

    // Reset in cycle 6 of EVAL clears everything including masks
    launch(16'h0001, 1'b0, 4'd0, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_state", {30'd0, in_ready, out_valid}, 32'h2);
    check("mrst_vec",   32'(vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(16'hFFFF, 1'b0, 4'd0, 32'd0);
    wait_result("rerun_ff", 0);
    check("rerun_ff_vec", 32'(vec), 32'd0);
    release_out("rerun_ff");
    launch(16'h0000, 1'b0, 4'd0, 32'd0);
    wait_result("rerun_00", 0);
    check("rerun_00_vec", 32'(vec), 32'd0);
    release_out("rerun_00");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tm_clause_eval.md
Name: tm_clause_eval

Overview:
- Sequential clause-evaluation engine for the Iris Tsetlin-machine classifier.
- Stores each clause's include mask, latches one booleanized sample, and evaluates one clause per cycle.
- Presents the six 2-bit positive/negative clause-output vectors to the downstream sum-and-threshold voter.
- Valid/ready handshake on both sides; a config write port loads the trained include masks.

Parameters:
- N_FEAT, 16, number of booleanized feature bits per sample (literals = 2*N_FEAT: x then ~x).
- N_CLAUSE, 2, clauses per polarity per class (fixed at 2 to match the voter's 2-bit vectors).
- N_CLASS, 3, number of classes; total clauses NC = N_CLASS*2*N_CLAUSE = 12.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  include-mask write strobe.
- cfg_addr  in  4  clause index 0..NC-1.
- cfg_data  in  2*N_FEAT  include mask; bit k<N_FEAT includes x[k], bit N_FEAT+k includes ~x[k].
- cfg_ready  out  1  high when a write is accepted (IDLE only).
- in_valid  in  1  sample valid.
- in_ready  out  1  engine can accept a sample.
- x  in  N_FEAT  booleanized sample.
- out_valid  out  1  clause vectors valid.
- out_ready  in  1  downstream accepts the vectors.
- pos_clause_1, neg_clause_1, pos_clause_2, neg_clause_2, pos_clause_3, neg_clause_3  out  2 each  clause outputs per class and polarity.

Behaviour:
- Clause index mapping: idx = class*4 + pol*2 + j, where class 0..2 maps to suffix _1.._3, pol 0 = pos / 1 = neg, and j is the bit position.
- Reset (async, rst_n=0):
  - State = IDLE; all masks = 0; sample register = 0; clause counter = 0.
  - All six clause vectors = 0; out_valid = 0.
  - in_ready = 1 and cfg_ready = 1 after release.
- FSM:
  - IDLE: in_ready = 1, cfg_ready = 1.
    - cfg_we with cfg_addr < NC writes the mask; cfg_addr >= NC is ignored.
    - in_valid latches x, clears all clause vectors, sets counter = 0, and moves to EVAL.
    - If cfg_we and in_valid arrive in the same cycle, the write completes and the sample is also accepted. The evaluation uses the newly written mask.
  - EVAL: in_ready = 0, cfg_ready = 0, and cfg_we is ignored.
    - Each cycle computes clause[counter] = AND over all included literals and registers it, then increments the counter.
    - After counter = NC-1 the FSM moves to DONE.
    - Occupies exactly NC = 12 cycles.
  - DONE: out_valid = 1 and clause vectors held stable; in_ready = 0, cfg_ready = 0.
    - out_valid && out_ready returns to IDLE the next cycle.
    - out_valid stays high indefinitely until out_ready.
- Latency: handshake accepted at edge T gives out_valid high from edge T+13. A new sample can be accepted at the earliest one cycle after the output handshake.
- Empty clause (mask all zero) outputs 0 (inference convention).
- Clause vectors change only during EVAL or at reset and are never updated while out_valid = 1.
- x changes after acceptance have no effect.
- Reset asserted mid-EVAL or in DONE aborts the operation, clears all state including masks, and drops out_valid asynchronously.

Test Plan:
- Reset check: after reset release, in_ready=1, cfg_ready=1, out_valid=0, all clause vectors 2'b00. A sample with all masks zero yields all-zero vectors at T+13.
- Single include: write mask bit 0 (x[0]) to clause 0 and bit N_FEAT+1 (~x[1]) to clause 5. Apply x=16'h0001 -> pos_clause_1=2'b01, neg_clause_1=2'b00, pos_clause_2=2'b10, all others 0. Apply x=16'h0003 -> pos_clause_2=2'b00.
- Contradictory mask: clause 10 includes both x[3] and ~x[3] -> neg_clause_3[0]=0 for every x.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Vectors stay stable, in_ready=0, and a new in_valid is not accepted. Raising out_ready -> IDLE the next cycle, with in_ready=1.
- Config gating: assert cfg_we during EVAL with a new mask -> ignored and the result is unchanged. A simultaneous cfg_we and in_valid in IDLE uses the new mask.
- Reset mid-operation: assert rst_n=0 at cycle 6 of EVAL -> out_valid=0, vectors 0, masks cleared. A re-run with x=16'hFFFF gives all-zero vectors.
